// File: rtl/cmp_config_loader.sv
// Streams a length-prefixed hash list from a FWFT FIFO into comparator memory.
// Optional checksum byte before the trailer: define CMP_CONFIG_CHECKSUM_EN.
`ifndef HASH_NUM_MSB
`define HASH_NUM_MSB 8
`endif
`ifndef HASH_COUNT_MSB
`define HASH_COUNT_MSB 9
`endif

module cmp_config_loader (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [7:0]                din,
    input  logic                      empty,
    output logic                      rd_en,
    input  logic                      cmp_busy,
    output logic [7:0]                dout,
    output logic                      wr_en,
    output logic [`HASH_NUM_MSB+2:0]  wr_addr,
    output logic [`HASH_COUNT_MSB:0]  hash_count,
    output logic                      config_valid,
    output logic                      error
);

    typedef enum logic [2:0] {
        COUNT_LO,
        COUNT_HI,
        DATA,
`ifdef CMP_CONFIG_CHECKSUM_EN
        CSUM,
`endif
        TRAILER
    } state_t;

    state_t state, next_state;

    logic [7:0]               count_lo;
    logic [`HASH_COUNT_MSB:0] count_reg;
    logic [`HASH_NUM_MSB+2:0] byte_cnt;
    logic [15:0]              full_count;
    logic                     count_bad;
    logic                     last_byte;
    logic                     consume;

    assign consume    = !empty && !cmp_busy && !RST;
    assign full_count = {din, count_lo};
    assign count_bad  = (full_count == 16'd0) || (full_count > 16'd512);
    // Compare in one extra bit so count*4 = 2048 is representable.
    assign last_byte  = ({1'b0, byte_cnt} == ({count_reg, 2'b00} - 12'd1));

`ifdef CMP_CONFIG_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_ok;
    assign csum_ok = (din == csum);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= COUNT_LO;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            COUNT_LO: if (consume) next_state = COUNT_HI;
            COUNT_HI: if (consume) next_state = count_bad ? COUNT_LO : DATA;
            DATA: begin
                if (consume && last_byte) begin
`ifdef CMP_CONFIG_CHECKSUM_EN
                    next_state = CSUM;
`else
                    next_state = TRAILER;
`endif
                end
            end
`ifdef CMP_CONFIG_CHECKSUM_EN
            CSUM:     if (consume) next_state = csum_ok ? TRAILER : COUNT_LO;
`endif
            TRAILER:  if (consume) next_state = COUNT_LO;
            default:  next_state = COUNT_LO;
        endcase
    end

    always_comb begin
        rd_en   = consume;
        wr_en   = consume && (state == DATA);
        dout    = din;
        wr_addr = byte_cnt;
    end

    // Datapath: count capture, write address, and status flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_lo     <= '0;
            count_reg    <= '0;
            byte_cnt     <= '0;
            hash_count   <= '0;
            config_valid <= 1'b0;
            error        <= 1'b0;
`ifdef CMP_CONFIG_CHECKSUM_EN
            csum         <= '0;
`endif
        end else if (consume) begin
            case (state)
                COUNT_LO: begin
                    count_lo     <= din;
                    config_valid <= 1'b0;
                    error        <= 1'b0;
`ifdef CMP_CONFIG_CHECKSUM_EN
                    csum         <= din;
`endif
                end
                COUNT_HI: begin
                    count_reg <= full_count[`HASH_COUNT_MSB:0];
                    byte_cnt  <= '0;
                    if (count_bad) error <= 1'b1;
`ifdef CMP_CONFIG_CHECKSUM_EN
                    csum      <= csum ^ din;
`endif
                end
                DATA: begin
                    if (!last_byte) byte_cnt <= byte_cnt + 1'b1;
`ifdef CMP_CONFIG_CHECKSUM_EN
                    csum <= csum ^ din;
`endif
                end
`ifdef CMP_CONFIG_CHECKSUM_EN
                CSUM: begin
                    if (!csum_ok) error <= 1'b1;
                end
`endif
                TRAILER: begin
                    if (din == 8'hCC) begin
                        hash_count   <= count_reg - 1'b1;
                        config_valid <= 1'b1;
                    end else begin
                        error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_config_loader.sv
// Scoreboard bench for cmp_config_loader: a FWFT FIFO model feeds packets,
// expected memory writes are queued at stimulus time and popped by a monitor.
`timescale 1ns/100ps

module tb_cmp_config_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  din;
    logic        empty;
    logic        rd_en;
    logic        cmp_busy = 1'b0;
    logic [7:0]  dout;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [9:0]  hash_count;
    logic        config_valid;
    logic        error;

    logic [7:0]  fifo_mem [0:8191];
    int          rd_ptr = 0;
    int          wr_ptr = 0;
    logic        gap = 1'b0;
    logic        took;
    logic [7:0]  xr;

    logic [18:0] sb [$];
    int          assertions = 0;
    int          failures = 0;
    int          writes_seen = 0;
    logic [10:0] last_addr = '0;

    assign empty = (rd_ptr == wr_ptr) || gap;
    assign din   = fifo_mem[rd_ptr[12:0]];

    cmp_config_loader dut (
        .CLK(CLK),
        .RST(RST),
        .din(din),
        .empty(empty),
        .rd_en(rd_en),
        .cmp_busy(cmp_busy),
        .dout(dout),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .hash_count(hash_count),
        .config_valid(config_valid),
        .error(error)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // FIFO model: a byte taken at a rising edge leaves the head just after it.
    initial begin
        forever begin
            @(posedge CLK);
            took = rd_en;
            #1;
            if (took) rd_ptr++;
        end
    end

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge CLK) begin
        if (wr_en) begin
            logic [18:0] exp;
            assertions++;
            if (cmp_busy || empty) begin
                failures++;
                $display("[TB] FAIL wr_guard: busy=%0b empty=%0b, required both 0", cmp_busy, empty);
            end
            assertions++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_write: addr=%0d data=%02h, required no write", wr_addr, dout);
            end else begin
                exp = sb.pop_front();
                if ({wr_addr, dout} !== exp) begin
                    failures++;
                    $display("[TB] FAIL write: addr=%0d data=%02h, required addr=%0d data=%02h",
                             wr_addr, dout, exp[18:8], exp[7:0]);
                end
            end
            writes_seen++;
            last_addr = wr_addr;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        fifo_mem[wr_ptr[12:0]] = b;
        wr_ptr++;
        xr = xr ^ b;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // seed 0 gives bytes 11,22,33,...; otherwise (i*7+seed) mod 256.
    task automatic sendPacket(input int cnt, input int seed, input logic [7:0] trailer);
        logic [15:0] c;
        logic [7:0]  b;
        logic [10:0] a;
        c  = cnt[15:0];
        xr = 8'h00;
        applyStimulus(c[7:0]);
        applyStimulus(c[15:8]);
        for (int i = 0; i < cnt * 4; i++) begin
            b = (seed == 0) ? 8'(8'h11 * (i + 1)) : 8'(i * 7 + seed);
            a = i[10:0];
            applyStimulus(b);
            sb.push_back({a, b});
        end
`ifdef CMP_CONFIG_CHECKSUM_EN
        applyStimulus(xr);
`endif
        applyStimulus(trailer);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (rd_ptr != wr_ptr && n < 5000) begin
            tick();
            n++;
        end
        assertions++;
        if (rd_ptr != wr_ptr) begin
            failures++;
            $display("[TB] FAIL drain_timeout: %0d bytes left, required 0", wr_ptr - rd_ptr);
        end
        tick();
        tick();
    endtask

    initial begin
        int base;
        int n;

        // Reset with a byte already waiting: nothing may be consumed.
        tick();
        sendPacket(2, 0, 8'hCC);
        tick();
        checkOutput("rst_rd_en", 16'(rd_en), 16'd0);
        checkOutput("rst_wr_en", 16'(wr_en), 16'd0);
        checkOutput("rst_hash_count", 16'(hash_count), 16'd0);
        checkOutput("rst_config_valid", 16'(config_valid), 16'd0);
        checkOutput("rst_error", 16'(error), 16'd0);
        RST = 1'b0;
        waitIdle();
        checkOutput("p2_config_valid", 16'(config_valid), 16'd1);
        checkOutput("p2_error", 16'(error), 16'd0);
        checkOutput("p2_hash_count", 16'(hash_count), 16'd1);

        $display("[TB] zero count packet");
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        waitIdle();
        checkOutput("zero_error", 16'(error), 16'd1);
        checkOutput("zero_config_valid", 16'(config_valid), 16'd0);
        checkOutput("zero_hash_count", 16'(hash_count), 16'd1);

        sendPacket(1, 1, 8'hCC);
        waitIdle();
        checkOutput("p1_error", 16'(error), 16'd0);
        checkOutput("p1_config_valid", 16'(config_valid), 16'd1);
        checkOutput("p1_hash_count", 16'(hash_count), 16'd0);

        $display("[TB] count 513");
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        waitIdle();
        checkOutput("c513_error", 16'(error), 16'd1);
        checkOutput("c513_config_valid", 16'(config_valid), 16'd0);

        $display("[TB] count 512");
        sendPacket(512, 3, 8'hCC);
        waitIdle();
        checkOutput("c512_last_addr", 16'(last_addr), 16'd2047);
        checkOutput("c512_hash_count", 16'(hash_count), 16'd511);
        checkOutput("c512_config_valid", 16'(config_valid), 16'd1);
        checkOutput("c512_error", 16'(error), 16'd0);

        $display("[TB] bad trailer");
        sendPacket(1, 2, 8'hCD);
        waitIdle();
        checkOutput("trl_error", 16'(error), 16'd1);
        checkOutput("trl_config_valid", 16'(config_valid), 16'd0);
        checkOutput("trl_hash_count", 16'(hash_count), 16'd511);

        $display("[TB] busy stall with empty gaps");
        base = writes_seen;
        sendPacket(3, 5, 8'hCC);
        n = 0;
        while (writes_seen < base + 3 && n < 200) begin
            tick();
            n++;
        end
        checkOutput("stall_reach_third", 16'(writes_seen >= base + 3), 16'd1);
        cmp_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            gap = (k % 2) == 1;
            tick();
        end
        cmp_busy = 1'b0;
        gap = 1'b0;
        waitIdle();
        checkOutput("stall_writes", 16'(writes_seen - base), 16'd12);
        checkOutput("stall_hash_count", 16'(hash_count), 16'd2);
        checkOutput("stall_config_valid", 16'(config_valid), 16'd1);

        $display("[TB] reset mid-packet");
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        sb.push_back({11'd0, 8'h11});
        sb.push_back({11'd1, 8'h22});
        waitIdle();
        checkOutput("partial_config_valid", 16'(config_valid), 16'd0);
        RST = 1'b1;
        tick();
        sendPacket(1, 9, 8'hCC);
        tick();
        checkOutput("rst2_rd_en", 16'(rd_en), 16'd0);
        checkOutput("rst2_wr_en", 16'(wr_en), 16'd0);
        checkOutput("rst2_hash_count", 16'(hash_count), 16'd0);
        RST = 1'b0;
        waitIdle();
        checkOutput("restart_last_addr", 16'(last_addr), 16'd3);
        checkOutput("restart_config_valid", 16'(config_valid), 16'd1);
        checkOutput("restart_hash_count", 16'(hash_count), 16'd0);

        checkOutput("scoreboard_left", 16'(sb.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
